// File: rtl/mbox_pkg.sv
// Shared constants for the mailbox FIFO: default geometry, almost-full threshold
// and the width of the dropped-write counter.
package mbox_pkg;

    localparam int unsigned WOU_DW_DEF   = 8;
    localparam int unsigned DEPTH_AW_DEF = 4;
    localparam int unsigned AFULL_TH_DEF = 12;
    localparam int unsigned OVF_CNT_W    = 16;

endpackage

// File: rtl/mbox_fifo_if.sv
// Mailbox FIFO signal bundle. The slave modport is the FIFO side; the master
// modport is the producer/consumer environment around it.
interface mbox_fifo_if #(
    parameter int unsigned WOU_DW   = mbox_pkg::WOU_DW_DEF,
    parameter int unsigned DEPTH_AW = mbox_pkg::DEPTH_AW_DEF
) ();

    // Producer side
    logic                           mbox_wr_i;
    logic [WOU_DW-1:0]              mbox_di;
    logic                           mbox_full_o;
    logic                           mbox_afull_o;
    logic                           mbox_empty_o;

    // Consumer side
    logic                           tx_valid_o;
    logic [WOU_DW-1:0]              tx_data_o;
    logic                           tx_ready_i;

    // Status and overflow reporting
    logic [DEPTH_AW:0]              level_o;
    logic                           ovf_o;
    logic                           ovf_clr_i;
    logic [mbox_pkg::OVF_CNT_W-1:0] ovf_cnt_o;

    modport master (
        output mbox_wr_i, mbox_di, tx_ready_i, ovf_clr_i,
        input  mbox_full_o, mbox_afull_o, mbox_empty_o, tx_valid_o, tx_data_o,
               level_o, ovf_o, ovf_cnt_o
    );

    modport slave (
        input  mbox_wr_i, mbox_di, tx_ready_i, ovf_clr_i,
        output mbox_full_o, mbox_afull_o, mbox_empty_o, tx_valid_o, tx_data_o,
               level_o, ovf_o, ovf_cnt_o
    );

endinterface

// File: rtl/mbox_fifo_ram.sv
// Simple dual-port storage for the mailbox FIFO: synchronous write,
// combinational read. Contents are deliberately not reset.
module mbox_fifo_ram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/mbox_fifo.sv
// Mailbox FIFO between the subsoc mailbox write port and the WOU transmitter.
// Every held word lives in the RAM; tx_data_o is a registered copy of the head
// so the consumer sees a stable word with no combinational path from mbox_di.
// level_o counts every held word, including the one presented on tx_data_o.
//
// Optional feature: define MBOX_FIFO_OVF_CNT_EN to build a saturating 16-bit
// count of dropped writes on ovf_cnt_o; otherwise ovf_cnt_o is tied to zero.
module mbox_fifo #(
    parameter int unsigned WOU_DW   = mbox_pkg::WOU_DW_DEF,
    parameter int unsigned DEPTH_AW = mbox_pkg::DEPTH_AW_DEF,
    parameter int unsigned AFULL_TH = mbox_pkg::AFULL_TH_DEF
) (
    input logic        clk,
    input logic        reset_n,
    mbox_fifo_if.slave bus
);

    import mbox_pkg::*;

    localparam int unsigned       CAPACITY  = 2**DEPTH_AW;
    localparam logic [DEPTH_AW:0] LVL_MAX   = (DEPTH_AW+1)'(CAPACITY);
    localparam logic [DEPTH_AW:0] LVL_AFULL = (DEPTH_AW+1)'(AFULL_TH);
    localparam logic [DEPTH_AW:0] LVL_ONE   = (DEPTH_AW+1)'(1);

    logic [DEPTH_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_AW-1:0] rd_next;
    logic [DEPTH_AW:0]   level_q, level_d;
    logic                tx_valid_q, tx_valid_d;
    logic [WOU_DW-1:0]   tx_data_q, tx_data_d;
    logic [WOU_DW-1:0]   ram_rdata;
    logic                full_q, afull_q, empty_q;
    logic                ovf_q, ovf_d;
    logic                run_q;
    logic                wr_acc, drop, pop;

    // run_q blocks writes on the first edge after reset release
    assign wr_acc  = bus.mbox_wr_i & ~full_q & run_q;
    assign drop    = bus.mbox_wr_i & full_q;
    assign pop     = tx_valid_q & bus.tx_ready_i;
    assign rd_next = rd_ptr_q + DEPTH_AW'(1);

    mbox_fifo_ram #(
        .DW (WOU_DW),
        .AW (DEPTH_AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.mbox_di),
        .raddr_i (rd_next),
        .rdata_o (ram_rdata)
    );

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + DEPTH_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_next;
        end
        unique case ({wr_acc, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Head register: refill from RAM after a pop, or take the incoming word
    // when it becomes the new head (empty, or the last word is leaving)
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (pop && (level_q > LVL_ONE)) begin
            tx_data_d = ram_rdata;
        end else if (pop || !tx_valid_q) begin
            tx_valid_d = wr_acc;
            if (wr_acc) begin
                tx_data_d = bus.mbox_di;
            end
        end
    end

    // Sticky overflow: a drop in the same cycle beats a clear
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // State registers and registered status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            full_q     <= (level_d == LVL_MAX);
            afull_q    <= (level_d >= LVL_AFULL);
            empty_q    <= (level_d == '0);
            ovf_q      <= ovf_d;
            run_q      <= 1'b1;
        end
    end

`ifdef MBOX_FIFO_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    // Saturating dropped-write counter; a clear with a drop leaves it at one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_q <= '0;
        end else if (bus.ovf_clr_i) begin
            ovf_cnt_q <= drop ? OVF_CNT_W'(1) : '0;
        end else if (drop && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    assign bus.ovf_cnt_o = ovf_cnt_q;
`else
    assign bus.ovf_cnt_o = '0;
`endif

    assign bus.mbox_full_o  = full_q;
    assign bus.mbox_afull_o = afull_q;
    assign bus.mbox_empty_o = empty_q;
    assign bus.tx_valid_o   = tx_valid_q;
    assign bus.tx_data_o    = tx_data_q;
    assign bus.level_o      = level_q;
    assign bus.ovf_o        = ovf_q;

endmodule

// File: tb/tb_mbox_fifo.sv
// Bench for mbox_fifo: directed scenarios plus a random phase, checked every
// cycle against a queue-based model of the mailbox behaviour.
module tb_mbox_fifo;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 4;
    localparam int unsigned TH  = 12;
    localparam int unsigned CAP = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    mbox_fifo_if #(.WOU_DW(DW), .DEPTH_AW(AW)) bus ();

    mbox_fifo #(
        .WOU_DW   (DW),
        .DEPTH_AW (AW),
        .AFULL_TH (TH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            m_ovf;
    int unsigned   m_cnt;
    bit            m_run;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        int unsigned exp_cnt;
`ifdef MBOX_FIFO_OVF_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        check({tag, ".level"}, 32'(bus.level_o), 32'(mq.size()));
        check({tag, ".valid"}, 32'(bus.tx_valid_o), 32'(mq.size() != 0));
        if (mq.size() != 0) check({tag, ".data"}, 32'(bus.tx_data_o), 32'(mq[0]));
        check({tag, ".empty"}, 32'(bus.mbox_empty_o), 32'(mq.size() == 0));
        check({tag, ".full"}, 32'(bus.mbox_full_o), 32'(mq.size() == CAP));
        check({tag, ".afull"}, 32'(bus.mbox_afull_o), 32'(mq.size() >= TH));
        check({tag, ".ovf"}, 32'(bus.ovf_o), 32'(m_ovf));
        check({tag, ".cnt"}, 32'(bus.ovf_cnt_o), exp_cnt);
    endtask

    // One clock: drive inputs, advance the model at the edge, check 1ns later
    task automatic cycle(input bit wr, input logic [DW-1:0] di, input bit rdy, input bit clr,
                         input string tag);
        bit full, pop, acc, drop;
        bus.mbox_wr_i  = wr;
        bus.mbox_di    = di;
        bus.tx_ready_i = rdy;
        bus.ovf_clr_i  = clr;
        full = (mq.size() == CAP);
        pop  = (mq.size() != 0) && rdy;
        acc  = wr && !full && m_run;
        drop = wr && full;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(di);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_cnt = drop ? 1 : 0;
        else if (drop && m_cnt != 32'hFFFF) m_cnt = m_cnt + 1;
        m_run = 1'b1;
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".level"}, 32'(bus.level_o), 32'd0);
        check({tag, ".valid"}, 32'(bus.tx_valid_o), 32'd0);
        check({tag, ".data"}, 32'(bus.tx_data_o), 32'd0);
        check({tag, ".empty"}, 32'(bus.mbox_empty_o), 32'd1);
        check({tag, ".full"}, 32'(bus.mbox_full_o), 32'd0);
        check({tag, ".afull"}, 32'(bus.mbox_afull_o), 32'd0);
        check({tag, ".ovf"}, 32'(bus.ovf_o), 32'd0);
        check({tag, ".cnt"}, 32'(bus.ovf_cnt_o), 32'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        m_run = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && mq.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0, tag);
        check({tag, ".drained"}, 32'(bus.mbox_empty_o), 32'd1);
    endtask

    initial begin
        bus.mbox_wr_i  = 1'b0;
        bus.mbox_di    = '0;
        bus.tx_ready_i = 1'b0;
        bus.ovf_clr_i  = 1'b0;
        model_reset();

        // Reset state while held in reset
        #12;
        check_reset_values("reset");
        reset_n = 1'b1;

        // First edge after release must not accept a write
        cycle(1'b1, 8'h33, 1'b0, 1'b0, "first_edge");

        // Single write into empty FIFO
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, "wr_a5");
        check("wr_a5.data_abs", 32'(bus.tx_data_o), 32'hA5);
        cycle(1'b0, '0, 1'b0, 1'b0, "hold_a5");
        drain("drain_a5");

        // Fill 0x00..0x0F, then an overflow write of 0xEE
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        check("fill.full_abs", 32'(bus.mbox_full_o), 32'd1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, "ovf_wr");
        check("ovf_wr.ovf_abs", 32'(bus.ovf_o), 32'd1);

        // Drain in order at one word per cycle
        for (int i = 0; i < 16; i++) begin
            check("stream.data_abs", 32'(bus.tx_data_o), 32'(i));
            cycle(1'b0, '0, 1'b1, 1'b0, "stream");
        end
        check("stream.valid_end", 32'(bus.tx_valid_o), 32'd0);

        // Clear, then a drop coinciding with a clear (set wins, count restarts at 1)
        cycle(1'b0, '0, 1'b0, 1'b1, "clr");
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, "fill2");
        cycle(1'b1, 8'h77, 1'b0, 1'b1, "drop_clr");
        cycle(1'b1, 8'h78, 1'b1, 1'b0, "full_wr_pop");
        cycle(1'b1, 8'h79, 1'b0, 1'b0, "refill");
        drain("drain2");

        // Steady level of 5 with simultaneous write and pop
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, "lvl5_fill");
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, "lvl5");
        check("lvl5.level_abs", 32'(bus.level_o), 32'd5);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, "rand");
        drain("drain3");

        // Asynchronous reset mid-transfer at level 9
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, "lvl9");
        check("lvl9.level_abs", 32'(bus.level_o), 32'd9);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_reset");
        #1;
        reset_n = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0, "post_reset_idle");
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, "post_reset_wr");
        check("post_reset_wr.data_abs", 32'(bus.tx_data_o), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mbox_fifo.md
MBOX_FIFO -- requirements
Module: mbox_fifo

Interface
REQ-001 SHALL have parameter WOU_DW, default 8: mailbox word width.
REQ-002 SHALL have parameter DEPTH_AW, default 4: log2 of capacity, so capacity is 2**DEPTH_AW words.
REQ-003 SHALL have parameter AFULL_TH, default 12: almost-full threshold; legal range 1..2**DEPTH_AW.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port mbox_wr_i, input, 1 bit: write strobe from subsoc mbox_wr_o.
REQ-007 SHALL have port mbox_di, input, WOU_DW bits: write data from subsoc mbox_do_o.
REQ-008 SHALL have ports mbox_full_o, mbox_afull_o and mbox_empty_o, output, 1 bit each: status returned to subsoc.
REQ-009 SHALL have port tx_valid_o, output, 1 bit: tx_data_o holds a valid word.
REQ-010 SHALL have port tx_data_o, output, WOU_DW bits: head-of-queue word.
REQ-011 SHALL have port tx_ready_i, input, 1 bit: downstream WOU transmitter accepts the word.
REQ-012 SHALL have port level_o, output, DEPTH_AW+1 bits: current occupancy.
REQ-013 SHALL have port ovf_o, output, 1 bit: sticky overflow flag.
REQ-014 SHALL have port ovf_clr_i, input, 1 bit: clears ovf_o and the overflow count.
REQ-015 SHALL have port ovf_cnt_o, output, 16 bits: count of dropped writes.

Function
REQ-016 Write accepted SHALL mean mbox_wr_i=1 and mbox_full_o=0; pop SHALL mean tx_valid_o=1 and tx_ready_i=1.
REQ-017 level_o SHALL count all held words, output register included; maximum 2**DEPTH_AW.
REQ-018 mbox_full_o, mbox_afull_o and mbox_empty_o SHALL be registered; they SHALL equal (level_o==2**DEPTH_AW), (level_o>=AFULL_TH) and (level_o==0) respectively.
REQ-019 A write into an empty FIFO at edge N SHALL give tx_valid_o=1 with that data after edge N; there SHALL be no same-cycle bypass.
REQ-020 tx_data_o and tx_valid_o SHALL hold stable while tx_valid_o=1 and tx_ready_i=0.
REQ-021 Data SHALL leave in strict write order; read and write pointers SHALL wrap modulo 2**DEPTH_AW.
REQ-022 A simultaneous accepted write and pop SHALL leave level_o unchanged and SHALL succeed at any level, except that a write while full is dropped even if a pop occurs in the same cycle.
REQ-023 A write while full SHALL not corrupt storage.
REQ-024 A write while full SHALL set ovf_o at the next edge.
REQ-025 ovf_clr_i SHALL clear ovf_o; if a drop occurs in the same cycle, set SHALL win over clear.
REQ-026 After a pop of the last word with no write, tx_valid_o SHALL deassert at the next edge.
REQ-027 Back-to-back pops with tx_ready_i held high SHALL sustain one word per cycle.

Reset
REQ-028 Asserting reset_n low SHALL asynchronously force: pointers=0, level_o=0, tx_valid_o=0, tx_data_o=0, mbox_empty_o=1, mbox_full_o=0, mbox_afull_o=0, ovf_o=0, ovf_cnt_o=0.
REQ-029 Asserting reset mid-transfer SHALL discard all stored words.
REQ-030 Storage RAM contents SHALL not be reset.
REQ-031 Deassertion SHALL be treated as synchronous to clk; no write SHALL be accepted on the first edge after release.

Configuration
REQ-032 With MBOX_FIFO_OVF_CNT_EN defined, ovf_cnt_o SHALL increment by 1 on each dropped write and saturate at 16'hFFFF.
REQ-033 With MBOX_FIFO_OVF_CNT_EN defined, ovf_clr_i SHALL zero ovf_cnt_o; a drop in the same cycle SHALL yield ovf_cnt_o=1.
REQ-034 Without MBOX_FIFO_OVF_CNT_EN, ovf_cnt_o SHALL be constant 0 and no counter SHALL be synthesized; ovf_o SHALL remain functional.

Structure
REQ-035 The shared package (mbox_pkg) SHALL hold the default WOU_DW, DEPTH_AW and AFULL_TH constants and the ovf_cnt width constant (16).
REQ-036 Storage SHALL be one sub-module, mbox_fifo_ram: a simple dual-port RAM with a synchronous write port and a read port.
REQ-037 Pointers, level, flags and the output register SHALL live in mbox_fifo.

Verification
REQ-038 Reset, then write 8'hA5 at edge N with tx_ready_i=0 -> after edge N: tx_valid_o=1, tx_data_o=8'hA5, level_o=1, mbox_empty_o=0.
REQ-039 Write 16 words 0x00..0x0F with tx_ready_i=0 -> mbox_afull_o=1 after the 12th write, mbox_full_o=1 after the 16th write.
REQ-040 Continuing from REQ-039, write a 17th word 0xEE -> word dropped, ovf_o=1, ovf_cnt_o=1 (macro on) or 0 (macro off).
REQ-041 Continuing from REQ-040, raise tx_ready_i -> words 0x00..0x0F appear one per cycle in order; 0xEE never appears; then tx_valid_o=0 and mbox_empty_o=1.
REQ-042 Hold level_o=5 with continuous write and pop for 40 cycles -> level_o stays 5, pointers wrap, order is preserved.
REQ-043 Pulse reset_n low while level_o=9 and tx_valid_o=1 -> all outputs take their reset values immediately; the next write behaves as in REQ-038.
